add3_arb_sched: RTL and testbench
=================================

# add3_arb_sched

Sequenced, shared three-operand adder. Two requesters compete for one N+2-bit two-input adder. A round-robin scheduler grants one requester, then the adder computes a+b+c over two add cycles. The full-width result is returned through a valid/ready handshake. The block sits between the add3 datapath users and serves as the area-reduced, multi-cycle counterpart of the combinational three-operand adders.

## Interface
Parameters:
- N, 8, operand width (N >= 2)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous and active-high
- req0_vld  in  1  requester 0 has an operation pending
- req0_rdy  out  1  requester 0 operands accepted this cycle
- a0, b0, c0  in  N each  requester 0 operands, unsigned
- req1_vld  in  1  requester 1 has an operation pending
- req1_rdy  out  1  requester 1 operands accepted this cycle
- a1, b1, c1  in  N each  requester 1 operands, unsigned
- res_vld  out  1  result valid
- res_rdy  in  1  consumer accepts result
- res_sum  out  N+2  a+b+c, full width, no truncation
- res_id  out  1  requester that issued the result (0/1)

## Operation
- States are IDLE, ADD1, ADD2 and DONE.
- **IDLE:**
  - If no requester is valid, stay in IDLE.
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester selected by the priority pointer `ptr`.
  - Granted reqX_rdy=1 combinationally in that same cycle. The transfer occurs on the edge where vld&&rdy.
  - On the transfer edge, latch a, b, c and the grant id into internal registers. Go to ADD1.
- **ADD1:** acc <= zext(a)+zext(b), held at N+2 bits. Go to ADD2.
- **ADD2:** acc <= acc+zext(c). Go to DONE.
- **DONE:**
  - res_vld=1. res_sum=acc. res_id=latched id.
  - On the edge where res_rdy=1: ptr <= ~id, so the requester just served gets low priority. Go to IDLE.
  - While res_rdy=0: res_vld, res_sum and res_id hold.
- Exactly one two-input adder instance is allowed. ADD1/ADD2 select its inputs through a mux.
- The full result is N+2 bits. No carry is dropped; the maximum is 3·(2^N−1).
- req0_rdy and req1_rdy are never both 1. Both are 0 outside IDLE.
- An ungranted requester that holds vld stays pending. It is not accepted until the next IDLE cycle in which it wins.
- Operands are sampled only on the transfer edge. Later changes on a/b/c have no effect.
- Requester contract: once vld rises, vld and operands stay stable until rdy. The block does not check this.
- There is no combinational path from res_rdy to req*_rdy, and none from req*_vld to res_vld.

## Timing
- **Reset (async, active-high)** forces:
  - state=IDLE, ptr=0
  - res_vld=0, res_sum=0, res_id=0
  - internal operand and acc registers = 0
  - req0_rdy and req1_rdy are 0 while rst=1
- **Reset mid-operation:** the operation is dropped. No res_vld is produced for it.
- **Latency:**
  - Transfer on edge k.
  - res_vld=1 from edge k+2 onward, i.e. visible in the cycle following edge k+2.
  - The result is consumed on the first edge ≥ k+3 where res_rdy=1.
- **Throughput:**
  - With res_rdy tied 1, the maximum is one operation per 4 cycles: IDLE, ADD1, ADD2, DONE.
  - Back-to-back operations are separated by exactly one IDLE cycle.
- **Simultaneous vld:** after reset ptr=0, so requester 0 wins first. Under continuous contention, grants alternate 0,1,0,1.
- **ptr update:** ptr changes only on a result-consume edge, never on the grant edge.
- **Single requester:** a requester may be granted repeatedly when the other has vld=0.

## Test plan
- **Single operation, max operands, N=8:** req0 a0=b0=c0=8'hFF, res_rdy=1.
  - req0_rdy pulses 1 cycle.
  - res_vld rises 2 edges after the transfer edge with res_sum=10'h2FD, res_id=0.
- **Contention:** req0 and req1 both held valid from reset release. Operands (1,2,3) on req0 and (10,20,30) on req1, repeated for 4 results.
  - Results come out in the order id 0,1,0,1 with sums 6,60,6,60.
  - Each pair of consecutive transfers is 4 cycles apart.
- **Backpressure:** hold res_rdy=0 for 5 cycles while in DONE, with req1_vld=1.
  - res_vld, res_sum and res_id stay stable.
  - req1_rdy=0 throughout.
  - Release res_rdy: consumed on the next edge; req1 is granted in the following IDLE.
- **Operand change after transfer:** change a0/b0/c0 to all-ones in the cycle after the transfer.
  - The result reflects the originally latched operands.
- **Reset mid-operation:** assert rst asynchronously during ADD2.
  - All outputs drop to 0 immediately.
  - After release: no res_vld until a new transfer is made; ptr=0.
- **Parameter sweep N=5:** run random operands for 1000 operations against a reference model of a+b+c.
  - The full 7-bit sum matches for every operation.
  - No requester is ever starved: each waits at most one other operation.

Source files
------------

// File: rtl/add3_arb_sched.sv
// Shared three-operand adder: two requesters arbitrated round-robin onto one
// N+2-bit adder that forms a+b+c over two cycles, result returned via valid/ready.
module add3_arb_sched #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_vld,
    output logic         req0_rdy,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic [N-1:0] c0,
    input  logic         req1_vld,
    output logic         req1_rdy,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    input  logic [N-1:0] c1,
    output logic         res_vld,
    input  logic         res_rdy,
    output logic [N+1:0] res_sum,
    output logic         res_id
);

    typedef enum logic [1:0] {
        IDLE,
        ADD1,
        ADD2,
        DONE
    } state_t;

    state_t       state;
    logic         ptr;
    logic         id;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [N-1:0] c_q;
    logic [N+1:0] acc;
    logic [N+1:0] add_x;
    logic [N+1:0] add_y;
    logic [N+1:0] add_s;
    logic         gnt0;
    logic         gnt1;

    // Grant only in IDLE; ptr breaks ties and favours whoever was not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_vld && (!req1_vld || !ptr)) begin
                gnt0 = 1'b1;
            end else if (req1_vld) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_rdy = gnt0;
    assign req1_rdy = gnt1;

    // The single shared adder: a+b in ADD1, acc+c in ADD2.
    always_comb begin
        if (state == ADD1) begin
            add_x = {2'b00, a_q};
            add_y = {2'b00, b_q};
        end else begin
            add_x = acc;
            add_y = {2'b00, c_q};
        end
        add_s = add_x + add_y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            id      <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            acc     <= '0;
            res_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        a_q   <= gnt1 ? a1 : a0;
                        b_q   <= gnt1 ? b1 : b0;
                        c_q   <= gnt1 ? c1 : c0;
                        id    <= gnt1;
                        state <= ADD1;
                    end
                end
                ADD1: begin
                    acc   <= add_s;
                    state <= ADD2;
                end
                ADD2: begin
                    acc     <= add_s;
                    res_vld <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (res_rdy) begin
                        res_vld <= 1'b0;
                        ptr     <= ~id;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign res_sum = acc;
    assign res_id  = id;

endmodule

// File: tb/tb_add3_arb_sched.sv
// Directed bench for add3_arb_sched (N=8) plus a randomised N=5 sweep
// checked against a bench-side arbitration and a+b+c model.
module tb_add3_arb_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0_vld, req0_rdy, req1_vld, req1_rdy;
    logic [7:0] a0, b0, c0, a1, b1, c1;
    logic       res_vld, res_rdy, res_id;
    logic [9:0] res_sum;

    logic       p_req0_vld, p_req0_rdy, p_req1_vld, p_req1_rdy;
    logic [4:0] p_a0, p_b0, p_c0, p_a1, p_b1, p_c1;
    logic       p_res_vld, p_res_rdy, p_res_id;
    logic [6:0] p_res_sum;

    int checks = 0;
    int failures = 0;

    add3_arb_sched #(.N(8)) dut (
        .clk(clk), .rst(rst),
        .req0_vld(req0_vld), .req0_rdy(req0_rdy), .a0(a0), .b0(b0), .c0(c0),
        .req1_vld(req1_vld), .req1_rdy(req1_rdy), .a1(a1), .b1(b1), .c1(c1),
        .res_vld(res_vld), .res_rdy(res_rdy), .res_sum(res_sum), .res_id(res_id)
    );

    add3_arb_sched #(.N(5)) dut5 (
        .clk(clk), .rst(rst),
        .req0_vld(p_req0_vld), .req0_rdy(p_req0_rdy), .a0(p_a0), .b0(p_b0), .c0(p_c0),
        .req1_vld(p_req1_vld), .req1_rdy(p_req1_rdy), .a1(p_a1), .b1(p_b1), .c1(p_c1),
        .res_vld(p_res_vld), .res_rdy(p_res_rdy), .res_sum(p_res_sum), .res_id(p_res_id)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req0_vld = 1'b1; req1_vld = 1'b1; res_rdy = 1'b1;
        a0 = 8'h11; b0 = 8'h22; c0 = 8'h33; a1 = 8'h44; b1 = 8'h55; c1 = 8'h66;
        p_req0_vld = 1'b0; p_req1_vld = 1'b0; p_res_rdy = 1'b0;
        p_a0 = '0; p_b0 = '0; p_c0 = '0; p_a1 = '0; p_b1 = '0; p_c1 = '0;
        #2;
        checks++; if (req0_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_req0_rdy got=%b exp=0", req0_rdy); end
        checks++; if (req1_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_req1_rdy got=%b exp=0", req1_rdy); end
        checks++; if (res_vld !== 1'b0) begin failures++; $display("[TB] FAIL reset_res_vld got=%b exp=0", res_vld); end
        checks++; if (res_sum !== 10'h000) begin failures++; $display("[TB] FAIL reset_res_sum got=%h exp=000", res_sum); end
        checks++; if (res_id !== 1'b0) begin failures++; $display("[TB] FAIL reset_res_id got=%b exp=0", res_id); end
        req0_vld = 1'b0; req1_vld = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        tick;
        checks++; if (res_vld !== 1'b0) begin failures++; $display("[TB] FAIL reset_release_res_vld got=%b exp=0", res_vld); end
    endtask

    task automatic test_single_max;
        a0 = 8'hFF; b0 = 8'hFF; c0 = 8'hFF; res_rdy = 1'b1; req0_vld = 1'b1;
        #1;
        checks++; if (req0_rdy !== 1'b1) begin failures++; $display("[TB] FAIL max_req0_rdy got=%b exp=1", req0_rdy); end
        checks++; if (req1_rdy !== 1'b0) begin failures++; $display("[TB] FAIL max_req1_rdy got=%b exp=0", req1_rdy); end
        tick;
        req0_vld = 1'b0;
        #1;
        checks++; if (req0_rdy !== 1'b0) begin failures++; $display("[TB] FAIL max_rdy_pulse got=%b exp=0", req0_rdy); end
        checks++; if (res_vld !== 1'b0) begin failures++; $display("[TB] FAIL max_vld_add1 got=%b exp=0", res_vld); end
        tick;
        checks++; if (res_vld !== 1'b0) begin failures++; $display("[TB] FAIL max_vld_add2 got=%b exp=0", res_vld); end
        tick;
        checks++; if (res_vld !== 1'b1) begin failures++; $display("[TB] FAIL max_vld_done got=%b exp=1", res_vld); end
        checks++; if (res_sum !== 10'h2FD) begin failures++; $display("[TB] FAIL max_sum got=%h exp=2fd", res_sum); end
        checks++; if (res_id !== 1'b0) begin failures++; $display("[TB] FAIL max_id got=%b exp=0", res_id); end
        tick;
        checks++; if (res_vld !== 1'b0) begin failures++; $display("[TB] FAIL max_consumed got=%b exp=0", res_vld); end
    endtask

    task automatic test_contention;
        int         ng;
        int         nr;
        int         gcyc[4];
        int         gid[4];
        int         rid[4];
        logic [9:0] rsum[4];
        ng = 0;
        nr = 0;
        for (int i = 0; i < 4; i++) begin
            gcyc[i] = -100; gid[i] = -1; rid[i] = -1; rsum[i] = '0;
        end
        rst = 1'b1;
        a0 = 8'd1; b0 = 8'd2; c0 = 8'd3; a1 = 8'd10; b1 = 8'd20; c1 = 8'd30;
        req0_vld = 1'b1; req1_vld = 1'b1; res_rdy = 1'b1;
        #1;
        tick;
        rst = 1'b0;
        #1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if ((req0_rdy || req1_rdy) && ng < 4) begin
                gcyc[ng] = cyc; gid[ng] = int'(req1_rdy); ng++;
            end
            if (res_vld && nr < 4) begin
                rid[nr] = int'(res_id); rsum[nr] = res_sum; nr++;
            end
            tick;
        end
        req0_vld = 1'b0; req1_vld = 1'b0;
        checks++; if (ng !== 4) begin failures++; $display("[TB] FAIL cont_grant_count got=%0d exp=4", ng); end
        checks++; if (nr !== 4) begin failures++; $display("[TB] FAIL cont_result_count got=%0d exp=4", nr); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (gid[i] !== (i % 2)) begin failures++; $display("[TB] FAIL cont_grant_id[%0d] got=%0d exp=%0d", i, gid[i], i % 2); end
            checks++; if (rid[i] !== (i % 2)) begin failures++; $display("[TB] FAIL cont_res_id[%0d] got=%0d exp=%0d", i, rid[i], i % 2); end
            checks++; if (rsum[i] !== ((i % 2) ? 10'd60 : 10'd6)) begin failures++; $display("[TB] FAIL cont_sum[%0d] got=%0d exp=%0d", i, rsum[i], (i % 2) ? 60 : 6); end
        end
        for (int i = 1; i < 4; i++) begin
            checks++; if (gcyc[i] - gcyc[i-1] !== 4) begin failures++; $display("[TB] FAIL cont_spacing[%0d] got=%0d exp=4", i, gcyc[i] - gcyc[i-1]); end
        end
        tick;
    endtask

    task automatic test_backpressure;
        rst = 1'b1; req0_vld = 1'b0; req1_vld = 1'b0; res_rdy = 1'b0;
        #1;
        tick;
        rst = 1'b0;
        a0 = 8'd5; b0 = 8'd6; c0 = 8'd7; req0_vld = 1'b1;
        #1;
        checks++; if (req0_rdy !== 1'b1) begin failures++; $display("[TB] FAIL bp_req0_rdy got=%b exp=1", req0_rdy); end
        tick;
        req0_vld = 1'b0; a1 = 8'd1; b1 = 8'd1; c1 = 8'd1; req1_vld = 1'b1;
        #1;
        checks++; if (req1_rdy !== 1'b0) begin failures++; $display("[TB] FAIL bp_req1_rdy_busy got=%b exp=0", req1_rdy); end
        tick;
        tick;
        for (int i = 0; i < 5; i++) begin
            checks++; if (res_vld !== 1'b1) begin failures++; $display("[TB] FAIL bp_hold_vld[%0d] got=%b exp=1", i, res_vld); end
            checks++; if (res_sum !== 10'd18) begin failures++; $display("[TB] FAIL bp_hold_sum[%0d] got=%0d exp=18", i, res_sum); end
            checks++; if (res_id !== 1'b0) begin failures++; $display("[TB] FAIL bp_hold_id[%0d] got=%b exp=0", i, res_id); end
            checks++; if (req1_rdy !== 1'b0) begin failures++; $display("[TB] FAIL bp_hold_req1_rdy[%0d] got=%b exp=0", i, req1_rdy); end
            tick;
        end
        res_rdy = 1'b1;
        #1;
        checks++; if (res_vld !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_vld got=%b exp=1", res_vld); end
        checks++; if (req1_rdy !== 1'b0) begin failures++; $display("[TB] FAIL bp_release_req1_rdy got=%b exp=0", req1_rdy); end
        tick;
        checks++; if (res_vld !== 1'b0) begin failures++; $display("[TB] FAIL bp_consumed got=%b exp=0", res_vld); end
        checks++; if (req1_rdy !== 1'b1) begin failures++; $display("[TB] FAIL bp_req1_granted got=%b exp=1", req1_rdy); end
        checks++; if (req0_rdy !== 1'b0) begin failures++; $display("[TB] FAIL bp_req0_not_granted got=%b exp=0", req0_rdy); end
        tick;
        req1_vld = 1'b0;
        tick;
        tick;
        checks++; if (res_vld !== 1'b1) begin failures++; $display("[TB] FAIL bp_r1_vld got=%b exp=1", res_vld); end
        checks++; if (res_sum !== 10'd3) begin failures++; $display("[TB] FAIL bp_r1_sum got=%0d exp=3", res_sum); end
        checks++; if (res_id !== 1'b1) begin failures++; $display("[TB] FAIL bp_r1_id got=%b exp=1", res_id); end
        tick;
    endtask

    task automatic test_operand_change;
        a0 = 8'd3; b0 = 8'd4; c0 = 8'd5; req0_vld = 1'b1; res_rdy = 1'b1;
        #1;
        checks++; if (req0_rdy !== 1'b1) begin failures++; $display("[TB] FAIL opchg_req0_rdy got=%b exp=1", req0_rdy); end
        tick;
        a0 = 8'hFF; b0 = 8'hFF; c0 = 8'hFF; req0_vld = 1'b0;
        tick;
        tick;
        checks++; if (res_vld !== 1'b1) begin failures++; $display("[TB] FAIL opchg_vld got=%b exp=1", res_vld); end
        checks++; if (res_sum !== 10'd12) begin failures++; $display("[TB] FAIL opchg_sum got=%0d exp=12", res_sum); end
        checks++; if (res_id !== 1'b0) begin failures++; $display("[TB] FAIL opchg_id got=%b exp=0", res_id); end
        tick;
    endtask

    task automatic test_reset_mid_op;
        a0 = 8'd1; b0 = 8'd1; c0 = 8'd1; req0_vld = 1'b1; res_rdy = 1'b1;
        #1;
        tick;
        req0_vld = 1'b0;
        tick;
        req0_vld = 1'b1; req1_vld = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        checks++; if (res_vld !== 1'b0) begin failures++; $display("[TB] FAIL midrst_vld got=%b exp=0", res_vld); end
        checks++; if (res_sum !== 10'd0) begin failures++; $display("[TB] FAIL midrst_sum got=%0d exp=0", res_sum); end
        checks++; if (res_id !== 1'b0) begin failures++; $display("[TB] FAIL midrst_id got=%b exp=0", res_id); end
        checks++; if (req0_rdy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_req0_rdy got=%b exp=0", req0_rdy); end
        checks++; if (req1_rdy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_req1_rdy got=%b exp=0", req1_rdy); end
        req0_vld = 1'b0; req1_vld = 1'b0;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (res_vld !== 1'b0) begin failures++; $display("[TB] FAIL midrst_no_result[%0d] got=%b exp=0", i, res_vld); end
        end
        a0 = 8'd1; b0 = 8'd2; c0 = 8'd3; a1 = 8'd10; b1 = 8'd20; c1 = 8'd30;
        req0_vld = 1'b1; req1_vld = 1'b1;
        #1;
        checks++; if (req0_rdy !== 1'b1) begin failures++; $display("[TB] FAIL midrst_ptr_req0 got=%b exp=1", req0_rdy); end
        checks++; if (req1_rdy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_ptr_req1 got=%b exp=0", req1_rdy); end
        tick;
        req0_vld = 1'b0; req1_vld = 1'b0;
        tick;
        tick;
        checks++; if (res_vld !== 1'b1) begin failures++; $display("[TB] FAIL midrst_new_vld got=%b exp=1", res_vld); end
        checks++; if (res_sum !== 10'd6) begin failures++; $display("[TB] FAIL midrst_new_sum got=%0d exp=6", res_sum); end
        checks++; if (res_id !== 1'b0) begin failures++; $display("[TB] FAIL midrst_new_id got=%b exp=0", res_id); end
        tick;
    endtask

    task automatic test_sweep_n5;
        logic       pend0, pend1, busy, rptr, exp_id, e0, e1, exp_vld;
        logic [6:0] exp_sum;
        int         phase, wait0, wait1, ops, cyc;
        pend0 = 1'b0; pend1 = 1'b0; busy = 1'b0; rptr = 1'b0; exp_id = 1'b0;
        exp_sum = '0; phase = 0; wait0 = 0; wait1 = 0; ops = 0; cyc = 0;
        p_req0_vld = 1'b0; p_req1_vld = 1'b0; p_res_rdy = 1'b0;
        rst = 1'b1;
        #1;
        tick;
        rst = 1'b0;
        while (ops < 1000 && cyc < 20000) begin
            if (!pend0 && $urandom_range(0, 3) != 0) begin
                pend0 = 1'b1;
                p_a0 = 5'($urandom_range(0, 31)); p_b0 = 5'($urandom_range(0, 31)); p_c0 = 5'($urandom_range(0, 31));
            end
            if (!pend1 && $urandom_range(0, 3) != 0) begin
                pend1 = 1'b1;
                p_a1 = 5'($urandom_range(0, 31)); p_b1 = 5'($urandom_range(0, 31)); p_c1 = 5'($urandom_range(0, 31));
            end
            p_req0_vld = pend0;
            p_req1_vld = pend1;
            p_res_rdy = ($urandom_range(0, 3) != 0);
            #1;
            e0 = !busy && pend0 && (!pend1 || !rptr);
            e1 = !busy && pend1 && !e0;
            exp_vld = busy && (phase >= 3);
            checks++; if (p_req0_rdy !== e0) begin failures++; $display("[TB] FAIL sweep_req0_rdy cyc=%0d got=%b exp=%b", cyc, p_req0_rdy, e0); end
            checks++; if (p_req1_rdy !== e1) begin failures++; $display("[TB] FAIL sweep_req1_rdy cyc=%0d got=%b exp=%b", cyc, p_req1_rdy, e1); end
            checks++; if (p_res_vld !== exp_vld) begin failures++; $display("[TB] FAIL sweep_res_vld cyc=%0d got=%b exp=%b", cyc, p_res_vld, exp_vld); end
            if (exp_vld) begin
                checks++; if (p_res_sum !== exp_sum) begin failures++; $display("[TB] FAIL sweep_sum cyc=%0d got=%0d exp=%0d", cyc, p_res_sum, exp_sum); end
                checks++; if (p_res_id !== exp_id) begin failures++; $display("[TB] FAIL sweep_id cyc=%0d got=%b exp=%b", cyc, p_res_id, exp_id); end
            end
            if (e0) begin
                exp_id = 1'b0;
                exp_sum = {2'b00, p_a0} + {2'b00, p_b0} + {2'b00, p_c0};
                busy = 1'b1; phase = 0; pend0 = 1'b0; wait0 = 0;
                if (pend1) begin
                    wait1++;
                    checks++; if (wait1 > 1) begin failures++; $display("[TB] FAIL sweep_starve1 cyc=%0d got=%0d exp<=1", cyc, wait1); end
                end
            end else if (e1) begin
                exp_id = 1'b1;
                exp_sum = {2'b00, p_a1} + {2'b00, p_b1} + {2'b00, p_c1};
                busy = 1'b1; phase = 0; pend1 = 1'b0; wait1 = 0;
                if (pend0) begin
                    wait0++;
                    checks++; if (wait0 > 1) begin failures++; $display("[TB] FAIL sweep_starve0 cyc=%0d got=%0d exp<=1", cyc, wait0); end
                end
            end else if (exp_vld && p_res_rdy) begin
                busy = 1'b0;
                rptr = ~exp_id;
                ops++;
            end
            tick;
            cyc++;
            if (busy) phase++;
        end
        p_req0_vld = 1'b0; p_req1_vld = 1'b0;
        checks++; if (ops !== 1000) begin failures++; $display("[TB] FAIL sweep_op_count got=%0d exp=1000", ops); end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single_max();
        test_contention();
        test_backpressure();
        test_operand_change();
        test_reset_mid_op();
        test_sweep_n5();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
